// File: rtl/addsub_iter.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle through a registered carry.
// Optional signed saturation is built only when ADDSUB_SAT_EN is defined.
module addsub_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_v;
    logic             r_z;
    logic             r_n;

    logic [CHUNK-1:0] w_a_chunk [NCHUNK];
    logic [CHUNK-1:0] w_b_chunk [NCHUNK];
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_final;
    logic             w_last;
    logic             w_sa;
    logic             w_sb;
    logic             w_sr;
    logic             w_v;
    logic             w_c;

    // Partial sums live in r_acc so the visible result only changes on completion.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign w_a_chunk[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_chunk[gi] = r_b[gi*CHUNK +: CHUNK];
            assign w_raw[gi*CHUNK +: CHUNK] = (r_idx == IDXW'(gi)) ? w_sum[CHUNK-1:0]
                                                                  : r_acc[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_sum  = {1'b0, w_a_chunk[r_idx]} + {1'b0, w_b_chunk[r_idx]} + (CHUNK+1)'(r_carry);
    assign w_last = (r_idx == IDXW'(NCHUNK - 1));

    // r_b holds ~b for subtract, so recover the original B sign with r_op.
    assign w_sa = r_a[WIDTH-1];
    assign w_sb = r_b[WIDTH-1] ^ r_op;
    assign w_sr = w_raw[WIDTH-1];
    assign w_v  = r_op ? ((w_sa != w_sb) && (w_sr != w_sa))
                       : ((w_sa == w_sb) && (w_sr != w_sa));
    assign w_c  = w_sum[CHUNK] ^ r_op;

`ifdef ADDSUB_SAT_EN
    logic r_sat;
    assign w_final = (w_v && r_sat) ? (w_sa ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}})
                                    : w_raw;
`else
    logic w_unused_sat;
    assign w_unused_sat = sat;
    assign w_final      = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
`ifdef ADDSUB_SAT_EN
            r_sat    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= op ? ~b : b;
                        r_op    <= op;
                        r_carry <= op;
                        r_idx   <= '0;
`ifdef ADDSUB_SAT_EN
                        r_sat   <= sat;
`endif
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_raw;
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_result <= w_final;
                        r_c      <= w_c;
                        r_v      <= w_v;
                        r_z      <= (w_final == '0);
                        r_n      <= w_final[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign flag_z    = r_z;
    assign flag_n    = r_n;

endmodule

// File: tb/tb_addsub_iter.sv
// Scoreboard bench for addsub_iter at WIDTH=64, CHUNK=16; follows ADDSUB_SAT_EN if defined.
module tb_addsub_iter;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic        sat = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        flag_c, flag_v, flag_z, flag_n;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t sb[$];

    addsub_iter #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sat(sat), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Reference model based on wide signed/unsigned arithmetic.
    function automatic exp_t model(input logic o, input logic s, input logic [63:0] x, input logic [63:0] y);
        exp_t               e;
        logic [64:0]        t;
        logic signed [65:0] sx, sy, st, sr;
        sx  = $signed({{2{x[63]}}, x});
        sy  = $signed({{2{y[63]}}, y});
        st  = o ? (sx - sy) : (sx + sy);
        e.r = o ? (x - y) : (x + y);
        t   = {1'b0, x} + {1'b0, y};
        e.c = o ? (x < y) : t[64];
        sr  = $signed({{2{e.r[63]}}, e.r});
        e.v = (st != sr);
`ifdef ADDSUB_SAT_EN
        if (e.v && s) e.r = x[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`else
        if (s) e.r = e.r;
`endif
        e.z = (e.r == 64'd0);
        e.n = e.r[63];
        return e;
    endfunction

    task automatic send(input logic o, input logic s, input logic [63:0] x, input logic [63:0] y, input bit push);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait: got %b want 1", in_ready);
        end
        in_valid = 1'b1; op = o; sat = s; a = x; b = y;
        if (push) sb.push_back(model(o, s, x, y));
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        op = ~o; sat = ~s; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    endtask

    task automatic receive(input int exp_lat);
        int   n = 0;
        exp_t e;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_wait: got %b want 1", out_valid);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (n !== exp_lat) begin
                errors++;
                $display("FAIL latency: got %0d want %0d", n, exp_lat);
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got result %h with no expectation", result);
        end else begin
            e = sb.pop_front();
            if ({result, flag_c, flag_v, flag_z, flag_n} !== {e.r, e.c, e.v, e.z, e.n}) begin
                errors++;
                $display("FAIL result: got %h c%b v%b z%b n%b want %h c%b v%b z%b n%b",
                         result, flag_c, flag_v, flag_z, flag_n, e.r, e.c, e.v, e.z, e.n);
            end else begin
                $display("txn ok: result=%h c=%b v=%b z=%b n=%b", result, flag_c, flag_v, flag_z, flag_n);
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n} !== {1'b1, 1'b0, 64'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h flags=%b%b%b%b want 1 0 0 0000",
                     in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n);
        end
    endtask

    task automatic test_directed();
        send(1'b1, 1'b0, 64'd5, 64'd3, 1'b1);                       receive(4); release_out();
        send(1'b1, 1'b0, 64'd0, 64'd1, 1'b1);                       receive(4); release_out();
        send(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);     receive(4); release_out();
        send(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);     receive(4); release_out();
        send(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);     receive(4); release_out();
        send(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);     receive(4); release_out();
        send(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1); receive(4); release_out();
    endtask

    task automatic test_backpressure();
        logic [67:0] cap;
        send(1'b0, 1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1);
        receive(4);
        cap = {result, flag_c, flag_v, flag_z, flag_n};
        in_valid = 1'b1; op = 1'b1; a = 64'd99; b = 64'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || {result, flag_c, flag_v, flag_z, flag_n} !== cap) begin
                errors++;
                $display("FAIL backpressure_hold: got vld=%b rdy=%b res=%h want 1 0 %h",
                         out_valid, in_ready, result, cap[67:4]);
            end
        end
        in_valid = 1'b0;
        release_out();
        send(1'b1, 1'b0, 64'd1000, 64'd1, 1'b1);
        receive(4);
        release_out();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        send(1'b0, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, result, flag_c, flag_v, flag_z, flag_n} !== {1'b0, 1'b1, 64'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b rdy=%b res=%h want 0 1 0", out_valid, in_ready, result);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_pulse: got out_valid pulse want none");
        end
        send(1'b1, 1'b0, 64'd7, 64'd9, 1'b1);
        receive(4);
        release_out();
    endtask

    task automatic test_back_to_back();
        int          prev = -1;
        logic [63:0] x, y;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 4 == 1) y = ~x;
            if (i % 4 == 2) x = {1'b0, {63{1'b1}}};
            send(1'($urandom), 1'($urandom), x, y, 1'b1);
            if (prev >= 0) begin
                checks++;
                if (accept_cyc - prev !== 6) begin
                    errors++;
                    $display("FAIL issue_interval: got %0d want 6", accept_cyc - prev);
                end
            end
            prev = accept_cyc;
            receive(4);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_iter.md
# addsub_iter

Parametrised, multi-cycle add/subtract unit that generalises the fixed 64-bit subtractor. It has configurable operand width and a registered carry chain processed one chunk per cycle, which keeps the critical path at CHUNK bits for wide operands. It runs one operation at a time under valid/ready handshakes on both sides and reports carry/borrow, overflow, zero and negative flags. It sits in the ALU datapath beside the combinational `addition`/`subtract` blocks and is used where WIDTH is too wide to close timing in one cycle.

## Interface
- `WIDTH`, 64: operand and result width in bits.
- `CHUNK`, 16: bits added per cycle.
  - WIDTH must be an integer multiple of CHUNK.
  - NCHUNK = WIDTH/CHUNK.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  unit can accept an operation.
- `op`  in  1  0 = add (a+b); 1 = subtract (a−b).
- `sat`  in  1  request signed saturation. Ignored unless ADDSUB_SAT_EN is defined.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  sum or difference.
- `flag_c`  out  1  add: carry out of the MSB. Subtract: borrow (= NOT carry out).
- `flag_v`  out  1  signed overflow.
- `flag_z`  out  1  result == 0, evaluated on the final (post-saturation) value.
- `flag_n`  out  1  result MSB.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - When in_valid=1 at a rising edge: latch a, op and sat; latch b as-is for add or bitwise-inverted for subtract.
  - Set the carry register to op (0 for add, 1 for subtract, giving two's-complement a + ~b + 1).
  - Clear the chunk index and go to BUSY.
- **BUSY**
  - in_ready=0.
  - Each cycle, add chunk i (bits i·CHUNK … i·CHUNK+CHUNK−1) of the latched operands plus the carry register.
  - Write the sum into the matching bits of the result register and register the chunk's carry out.
  - After chunk NCHUNK−1, compute flags and saturation and go to DONE.
- **DONE**
  - out_valid=1; result and flags are held stable.
  - When out_ready=1 at a rising edge, go to IDLE. The next accept occurs at the following edge at the earliest.
- Flag computation (sa, sb = original operand MSBs; sr = raw result MSB):
  - Add: v = (sa==sb) & (sr!=sa).
  - Subtract: v = (sa!=sb) & (sr!=sa).
- Operand inputs are don't-care outside the IDLE accept edge. Changes during BUSY or DONE have no effect.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Reset in any state, including mid-BUSY:
  - The operation is abandoned and the next state is IDLE.
  - result = 0, all flags = 0, out_valid = 0, in_ready = 1 from the cycle after the reset edge.
  - No partial result is ever presented.

## Timing
- Accept edge to out_valid rising: NCHUNK clock edges. Example: WIDTH=64, CHUNK=16 gives out_valid high 4 cycles after acceptance.
- CHUNK=WIDTH gives a one-cycle BUSY.
- Minimum issue interval with out_ready tied high: NCHUNK+2 cycles.
- Outputs are registered only; there are no combinational input-to-output paths.
- in_ready is a function of state only.
- The combinational path per cycle is one CHUNK-bit add.

## Configuration
- `ADDSUB_SAT_EN` defined:
  - On entering DONE with v=1 and the latched sat=1, result is clamped to the signed extreme: 0x7FF…F if sa=0, else 0x800…0.
  - flag_v stays 1 and flag_c keeps its raw value.
  - flag_z and flag_n reflect the clamped value.
- `ADDSUB_SAT_EN` undefined:
  - The sat port is present but unused.
  - result always wraps modulo 2^WIDTH.
  - No saturation logic is synthesised.

## Test plan
All cases use WIDTH=64, CHUNK=16.
- **Simple subtract:** sub a=5, b=3 → result=2, c=0, v=0, z=0, n=0; out_valid exactly 4 cycles after the accept edge.
- **Full borrow chain:** sub a=0, b=1 → result=0xFFFF_FFFF_FFFF_FFFF, c=1, n=1, v=0, z=0. Borrow propagates through all 4 chunks.
- **Signed overflow and saturation:** add a=0x7FFF_FFFF_FFFF_FFFF, b=1.
  - Without the macro, or with sat=0 → result=0x8000_0000_0000_0000, v=1, n=1.
  - With ADDSUB_SAT_EN and sat=1 → result=0x7FFF_FFFF_FFFF_FFFF, v=1, n=0.
- **Unsigned carry out:** add a=0xFFFF_FFFF_FFFF_FFFF, b=1 → result=0, c=1, z=1, v=0.
- **Backpressure:** out_ready low for 5 cycles after out_valid rises → result and flags unchanged, in_ready=0, a new in_valid is ignored. Then raise out_ready → IDLE next cycle, and the next accept completes normally.
- **Reset mid-operation:** rst high on the 2nd BUSY cycle → next cycle out_valid=0, in_ready=1, result=0. No out_valid pulse appears for the aborted operation.
